load_pattern_gen: RTL and testbench
===================================

# load_pattern_gen

Parametrised packet-load generator for SSD-controller link bring-up and throughput testing. It emits framed test packets on a valid/ready stream, with a selectable payload pattern, a packet count and an inter-packet gap. Each packet carries a 12-byte header, a payload and an internally computed CRC-16. The block sits in front of the write-path FIFO and replaces free-running fixed-width generation with a flow-controlled, width-generic source.

## Interface
- DW, 16, output width in bits; legal values are 16 and 32. BPW = DW/8 bytes per word.
- PRBS_SEED, 15'h7FFF, PRBS-15 seed, reloaded at the start of every packet.

- clk  in  1  single clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- stop  in  1  level; finish the current packet, then go to IDLE.
- mode  in  2  payload pattern: 00 incrementing, 01 PRBS-15, 10 fixed byte, 11 all-zero.
- fixed_byte  in  8  payload byte used in mode 10.
- packet_head  in  32  sync word.
- flag_set  in  16  payload identifier.
- length_set  in  24  total packet bytes, CRC included.
- num_packets  in  16  packets per run; 0 = continuous.
- gap_cycles  in  8  idle cycles between packets.
- out_data  out  DW  packet word, big-endian (byte 0 in the MSBs).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  marks the final word of a packet.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at the end of a finite run.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pkt_seq  out  24  sequence number of the packet currently being sent.

## Operation
- Configuration inputs are latched on an accepted start and ignored until the block returns to IDLE.
- Packet byte map, with L = length_set:
  - bytes 0–3: packet_head.
  - bytes 4–6: pkt_seq.
  - bytes 7–8: flag_set.
  - bytes 9–11: L.
  - bytes 12 to L-3: payload.
  - bytes L-2 and L-1: CRC, MSB first.
- Payload byte k (k = 0 at byte 12), by mode:
  - 00: k[7:0].
  - 01: next 8 PRBS-15 output bits, MSB-first. Polynomial x^15+x^14+1; new bit = s[14]^s[13], shifted into s[0]; output bit = new bit.
  - 10: fixed_byte.
  - 11: 8'h00.
- CRC is CRC-16/CCITT-FALSE: polynomial 0x1021, init 0xFFFF, no reflection, no final xor. It covers bytes 0 to L-3 and is re-initialised per packet. When the CRC shares a word with payload (DW=32), it includes the preceding lanes of that same word.
- Start validation: L must satisfy L ≥ 16 and L mod BPW == 0. Otherwise cfg_err pulses, the block stays in IDLE and no word is emitted.
- States:
  - IDLE → SEND on a valid start.
  - SEND → GAP when the last word is transferred and more packets remain and gap_cycles > 0.
  - SEND → SEND (back-to-back) in the same case with gap_cycles = 0.
  - SEND → DONE when the count is reached, or when stop has been seen during the packet.
  - GAP → SEND after gap_cycles cycles.
  - DONE → IDLE after one cycle. done is high during DONE only when the run ended on the count, not on stop.
- Packet count: pkt_seq is 0 for the first packet after start and increments after each last transfer, wrapping 2^24-1 → 0. A finite run ends after num_packets packets.
- stop is sticky once seen during SEND or GAP:
  - In GAP, it goes straight to DONE.
  - In SEND, the current packet is never truncated.
  - stop in IDLE is ignored.

## Timing
- Reset values: out_data 0, out_valid 0, out_last 0, busy 0, done 0, cfg_err 0, pkt_seq 0, state IDLE.
- Start latency: start seen at edge n puts the first word valid after edge n+1. cfg_err rises after edge n+1.
- All outputs are registered. out_data and out_last are held stable while out_valid=1 and out_ready=0. out_valid never drops without a transfer.
- On a transfer the next word is presented the following cycle, with no bubble. A packet of L bytes at ready=1 takes exactly L/BPW cycles.
- gap_cycles = G gives exactly G cycles with out_valid=0 between the last transfer and the next first word.
- done and busy fall together one cycle after the final last transfer.
- Reset mid-packet: all outputs return to reset values immediately. No partial packet resumes.

## Test plan
- DW=16, L=16, mode 00, head 0x5716EB90, flag 0xA5C3, num 1, ready=1 -> words 5716, EB90, 0000, 00A5, C300, 0010, 0001, then CRC(bytes 0–13); out_last on word 8; done one cycle later.
- DW=32, L=20, same fields -> 5716EB90, 000000A5, C3000014, 00010203, {0405, CRC}; out_last on word 5.
- Mode 01 with random out_ready stalls -> first payload byte 0x00, stream matches the PRBS/CRC model, no data change while stalled, no lost or duplicated words.
- num 3, gap 2 -> pkt_seq 0, 1, 2 in header bytes 4–6; exactly 2 invalid cycles between packets; a single done pulse.
- L=15 (DW=16) and L=18 (DW=32) -> cfg_err pulse, out_valid stays 0, busy stays 0.
- stop mid-packet in continuous mode -> the packet completes with a correct CRC, no done pulse, then IDLE. nRST low mid-packet -> all outputs 0 at once.

Source files
------------

// File: rtl/load_pattern_gen_if.sv
// Stream link carrying generated packet words from the pattern generator.
// Handshake: a word moves on every rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// master holds out_data/out_last stable and never drops out_valid. out_ready
// may change at any time and has no effect while out_valid is low.
interface load_pattern_gen_if #(
   parameter int DW = 16
);
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/load_pattern_gen.sv
// Framed test-packet generator: 12-byte header, patterned payload, CRC-16
// trailer, emitted on a flow-controlled stream of DW-bit big-endian words.
module load_pattern_gen #(
   parameter int          DW        = 16,
   parameter logic [14:0] PRBS_SEED = 15'h7FFF
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        start,
   input  logic        stop,
   input  logic [1:0]  mode,
   input  logic [7:0]  fixed_byte,
   input  logic [31:0] packet_head,
   input  logic [15:0] flag_set,
   input  logic [23:0] length_set,
   input  logic [15:0] num_packets,
   input  logic [7:0]  gap_cycles,
   load_pattern_gen_if.master link,
   output logic        busy,
   output logic        done,
   output logic        cfg_err,
   output logic [23:0] pkt_seq,
   output logic [1:0]  dbg_state
);

   localparam int         BPW      = DW / 8;
   localparam logic [1:0] LEN_MASK = 2'(BPW - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3} state_t;

   state_t state_q, state_d;

   // Configuration latched on an accepted start
   logic [1:0]    mode_q;
   logic [7:0]    fixed_q;
   logic [31:0]   head_q;
   logic [15:0]   flag_q;
   logic [23:0]   len_q;
   logic [15:0]   num_q;
   logic [7:0]    gap_q;

   // Per-packet generator state: next byte offset, running CRC, PRBS register
   logic [23:0]   pos_q;
   logic [15:0]   crc_q;
   logic [14:0]   prbs_q;
   logic [15:0]   cnt_q;
   logic [7:0]    gap_cnt_q;
   logic          stop_seen_q;
   logic          rej_q;

   // Registered outputs
   logic [DW-1:0] data_q;
   logic          valid_q, last_q, busy_q, done_q, cfg_err_q;
   logic [23:0]   seq_q;

   // Control strobes
   logic          start_ok, xfer, last_xfer, count_hit, stop_any, load, restart;

   // Generator results for the word about to be loaded
   logic [23:0]   g_pos, g_seq, b;
   logic [15:0]   g_crc, c;
   logic [14:0]   g_prbs, p;
   logic [DW-1:0] w;
   logic [7:0]    lb, pb, k8;
   logic          nb, gen_last;

   // Next-output values
   logic [DW-1:0] data_d;
   logic          valid_d, last_d, done_d;

   function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] d);
      logic [15:0] r;
      r = crc_in ^ {d, 8'h00};
      for (int j = 0; j < 8; j++) begin
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      return r;
   endfunction

   assign start_ok  = (length_set >= 24'd16) && ((length_set[1:0] & LEN_MASK) == 2'b00);
   assign xfer      = valid_q & link.out_ready;
   assign last_xfer = xfer & last_q;
   assign count_hit = (num_q != 16'd0) && ((cnt_q + 16'd1) == num_q);
   assign stop_any  = stop | stop_seen_q;

   // State register
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and word-load strobes
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      restart = 1'b0;
      case (state_q)
         S_IDLE: if (start && start_ok) state_d = S_SEND;
         S_SEND: begin
            if (last_xfer) begin
               if (count_hit || stop_any) begin
                  state_d = S_DONE;
               end else if (gap_q == 8'd0) begin
                  load    = 1'b1;
                  restart = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end else if ((!valid_q || xfer) && (pos_q != len_q)) begin
               load = 1'b1;
            end
         end
         S_GAP: begin
            if (stop_any) begin
               state_d = S_DONE;
            end else if (gap_cnt_q == 8'd0) begin
               state_d = S_SEND;
               load    = 1'b1;
               restart = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Word generator: builds BPW bytes starting at g_pos, advancing CRC and PRBS lane by lane
   always_comb begin
      g_pos  = restart ? 24'd0 : pos_q;
      g_crc  = restart ? 16'hFFFF : crc_q;
      g_prbs = restart ? PRBS_SEED : prbs_q;
      g_seq  = (restart && state_q == S_SEND) ? seq_q + 24'd1 : seq_q;
      c      = g_crc;
      p      = g_prbs;
      w      = '0;
      b      = '0;
      lb     = '0;
      pb     = '0;
      k8     = '0;
      nb     = 1'b0;
      for (int i = 0; i < BPW; i++) begin
         b  = g_pos + 24'(i);
         k8 = 8'(b - 24'd12);
         lb = 8'h00;
         if (b < 24'd12) begin
            case (b[3:0])
               4'd0:  lb = head_q[31:24];
               4'd1:  lb = head_q[23:16];
               4'd2:  lb = head_q[15:8];
               4'd3:  lb = head_q[7:0];
               4'd4:  lb = g_seq[23:16];
               4'd5:  lb = g_seq[15:8];
               4'd6:  lb = g_seq[7:0];
               4'd7:  lb = flag_q[15:8];
               4'd8:  lb = flag_q[7:0];
               4'd9:  lb = len_q[23:16];
               4'd10: lb = len_q[15:8];
               default: lb = len_q[7:0];
            endcase
         end else if (b < len_q - 24'd2) begin
            for (int j = 7; j >= 0; j--) begin
               nb    = p[14] ^ p[13];
               p     = {p[13:0], nb};
               pb[j] = nb;
            end
            case (mode_q)
               2'b00:   lb = k8;
               2'b01:   lb = pb;
               2'b10:   lb = fixed_q;
               default: lb = 8'h00;
            endcase
         end else if (b == len_q - 24'd2) begin
            lb = c[15:8];
         end else begin
            lb = c[7:0];
         end
         if (b < len_q - 24'd2) c = crc_byte(c, lb);
         w[DW-1-8*i -: 8] = lb;
      end
      gen_last = ((g_pos + 24'(BPW)) == len_q);
   end

   // Next values of the registered stream outputs and the done pulse
   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         last_d  = gen_last;
         data_d  = w;
      end else if (xfer) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
      done_d = (state_q == S_SEND) && last_xfer && count_hit;
   end

   // Datapath, configuration and output registers
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         mode_q      <= '0;
         fixed_q     <= '0;
         head_q      <= '0;
         flag_q      <= '0;
         len_q       <= '0;
         num_q       <= '0;
         gap_q       <= '0;
         pos_q       <= '0;
         crc_q       <= 16'hFFFF;
         prbs_q      <= PRBS_SEED;
         cnt_q       <= '0;
         gap_cnt_q   <= '0;
         stop_seen_q <= 1'b0;
         rej_q       <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         seq_q       <= '0;
      end else begin
         rej_q     <= (state_q == S_IDLE) && start && !start_ok;
         cfg_err_q <= rej_q;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= done_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         data_q    <= data_d;
         if ((state_q == S_SEND || state_q == S_GAP) && stop) stop_seen_q <= 1'b1;
         if (load) begin
            pos_q  <= g_pos + 24'(BPW);
            crc_q  <= c;
            prbs_q <= p;
         end
         if (last_xfer) begin
            seq_q <= seq_q + 24'd1;
            cnt_q <= cnt_q + 16'd1;
         end
         if (state_q == S_SEND && last_xfer && state_d == S_GAP) begin
            gap_cnt_q <= gap_q - 8'd1;
         end else if (state_q == S_GAP && gap_cnt_q != 8'd0) begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
         end
         if (state_q == S_IDLE && start && start_ok) begin
            mode_q      <= mode;
            fixed_q     <= fixed_byte;
            head_q      <= packet_head;
            flag_q      <= flag_set;
            len_q       <= length_set;
            num_q       <= num_packets;
            gap_q       <= gap_cycles;
            pos_q       <= '0;
            crc_q       <= 16'hFFFF;
            prbs_q      <= PRBS_SEED;
            cnt_q       <= '0;
            seq_q       <= '0;
            stop_seen_q <= 1'b0;
         end
      end
   end

   assign link.out_data  = data_q;
   assign link.out_valid = valid_q;
   assign link.out_last  = last_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign cfg_err        = cfg_err_q;
   assign pkt_seq        = seq_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_load_pattern_gen.sv
// Directed bench for load_pattern_gen: one 16-bit and one 32-bit instance
// share configuration and start; each has its own ready and stream scoreboard.
`timescale 1ns/1ps
module tb_load_pattern_gen;

   // clock / reset
   logic clk = 1'b0;
   logic nRST;
   always #5 clk = ~clk;

   // shared configuration
   logic        start, stop;
   logic [1:0]  mode;
   logic [7:0]  fixed_byte;
   logic [31:0] packet_head;
   logic [15:0] flag_set;
   logic [23:0] length_set;
   logic [15:0] num_packets;
   logic [7:0]  gap_cycles;
   logic        rdy16, rdy32;

   logic        busy16, done16, cfg_err16, busy32, done32, cfg_err32;
   logic [23:0] seq16, seq32;
   logic [1:0]  st16, st32;

   load_pattern_gen_if #(.DW(16)) if16 ();
   load_pattern_gen_if #(.DW(32)) if32 ();
   assign if16.out_ready = rdy16;
   assign if32.out_ready = rdy32;

   load_pattern_gen #(.DW(16)) u16 (
      .clk(clk), .nRST(nRST), .start(start), .stop(stop), .mode(mode),
      .fixed_byte(fixed_byte), .packet_head(packet_head), .flag_set(flag_set),
      .length_set(length_set), .num_packets(num_packets), .gap_cycles(gap_cycles),
      .link(if16.master), .busy(busy16), .done(done16), .cfg_err(cfg_err16),
      .pkt_seq(seq16), .dbg_state(st16));

   load_pattern_gen #(.DW(32)) u32 (
      .clk(clk), .nRST(nRST), .start(start), .stop(stop), .mode(mode),
      .fixed_byte(fixed_byte), .packet_head(packet_head), .flag_set(flag_set),
      .length_set(length_set), .num_packets(num_packets), .gap_cycles(gap_cycles),
      .link(if32.master), .busy(busy32), .done(done32), .cfg_err(cfg_err32),
      .pkt_seq(seq32), .dbg_state(st32));

   // scoreboard
   int errors = 0;
   int checks = 0;
   logic [16:0] exp16_q[$];
   logic [32:0] exp32_q[$];
   int  done16_cnt, done32_cnt;
   int  exp_gap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference model: builds one packet from the current configuration
   task automatic push_packet(input logic [23:0] seq, input bit en16, input bit en32);
      logic [7:0]  pkt[$];
      logic [95:0] hdr;
      logic [14:0] s;
      logic [15:0] crc;
      logic [7:0]  d;
      logic        nb, fb;
      int          len;
      len = int'(length_set);
      hdr = {packet_head, seq, flag_set, length_set};
      s   = 15'h7FFF;
      crc = 16'hFFFF;
      for (int bi = 0; bi < len - 2; bi++) begin
         if (bi < 12) begin
            d = hdr[95 - 8*bi -: 8];
         end else begin
            case (mode)
               2'b00: d = 8'(bi - 12);
               2'b01: begin
                  for (int j = 7; j >= 0; j--) begin
                     nb   = s[14] ^ s[13];
                     s    = {s[13:0], nb};
                     d[j] = nb;
                  end
               end
               2'b10: d = fixed_byte;
               default: d = 8'h00;
            endcase
         end
         for (int j = 7; j >= 0; j--) begin
            fb  = crc[15] ^ d[j];
            crc = {crc[14:0], 1'b0};
            if (fb) crc = crc ^ 16'h1021;
         end
         pkt.push_back(d);
      end
      pkt.push_back(crc[15:8]);
      pkt.push_back(crc[7:0]);
      if (en16) for (int i = 0; i < len/2; i++)
         exp16_q.push_back({(i == len/2 - 1), pkt[2*i], pkt[2*i+1]});
      if (en32) for (int i = 0; i < len/4; i++)
         exp32_q.push_back({(i == len/4 - 1), pkt[4*i], pkt[4*i+1], pkt[4*i+2], pkt[4*i+3]});
   endtask

   // stream monitors: word order, stall stability, inter-packet gap, done count
   logic        held16, gap_on16, held32, gap_on32;
   logic [16:0] hold16;
   logic [32:0] hold32;
   int          gap_cnt16, gap_cnt32;

   always @(negedge clk) begin
      if (!nRST) begin
         held16 = 1'b0; gap_on16 = 1'b0;
      end else begin
         if (held16) chk("hold16", {if16.out_valid, if16.out_last, if16.out_data}, {1'b1, hold16});
         held16 = if16.out_valid && !rdy16;
         hold16 = {if16.out_last, if16.out_data};
         if (gap_on16 && if16.out_valid) begin
            chk("gap16", gap_cnt16, exp_gap);
            gap_on16 = 1'b0;
         end else if (gap_on16) begin
            gap_cnt16++;
         end
         if (!busy16) gap_on16 = 1'b0;
         if (if16.out_valid && rdy16) begin
            if (exp16_q.size() == 0) chk("extra16", {if16.out_last, if16.out_data}, 'x);
            else chk("word16", {if16.out_last, if16.out_data}, exp16_q.pop_front());
            if (if16.out_last) begin gap_on16 = 1'b1; gap_cnt16 = 0; end
         end
         if (done16) done16_cnt++;
      end
   end

   always @(negedge clk) begin
      if (!nRST) begin
         held32 = 1'b0; gap_on32 = 1'b0;
      end else begin
         if (held32) chk("hold32", {if32.out_valid, if32.out_last, if32.out_data}, {1'b1, hold32});
         held32 = if32.out_valid && !rdy32;
         hold32 = {if32.out_last, if32.out_data};
         if (gap_on32 && if32.out_valid) begin
            chk("gap32", gap_cnt32, exp_gap);
            gap_on32 = 1'b0;
         end else if (gap_on32) begin
            gap_cnt32++;
         end
         if (!busy32) gap_on32 = 1'b0;
         if (if32.out_valid && rdy32) begin
            if (exp32_q.size() == 0) chk("extra32", {if32.out_last, if32.out_data}, 'x);
            else chk("word32", {if32.out_last, if32.out_data}, exp32_q.pop_front());
            if (if32.out_last) begin gap_on32 = 1'b1; gap_cnt32 = 0; end
         end
         if (done32) done32_cnt++;
      end
   end

   // driver tasks
   task automatic set_cfg(input logic [1:0] m, input logic [23:0] len, input logic [15:0] num,
                          input logic [7:0] gap);
      mode        = m;
      length_set  = len;
      num_packets = num;
      gap_cycles  = gap;
      exp_gap     = int'(gap);
      done16_cnt  = 0;
      done32_cnt  = 0;
   endtask

   // start is high across exactly one rising edge; returns just after that edge
   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_until_idle(input int budget, input bit rand_rdy);
      int cyc = 0;
      @(negedge clk);
      while ((busy16 || busy32 || if16.out_valid || if32.out_valid) && cyc < budget) begin
         @(posedge clk); #1;
         if (rand_rdy) begin
            rdy16 = 1'($urandom_range(0, 1));
            rdy32 = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         cyc++;
      end
      chk("idle_within_budget", (cyc < budget), 1);
      rdy16 = 1'b1;
      rdy32 = 1'b1;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_16"}, {if16.out_data, if16.out_valid, if16.out_last, busy16, done16, cfg_err16, seq16, st16}, '0);
      chk({tag, "_32"}, {if32.out_data, if32.out_valid, if32.out_last, busy32, done32, cfg_err32, seq32, st32}, '0);
   endtask

   // watchdog
   initial begin
      #2ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // directed sequence
   initial begin
      int n;
      nRST = 1'b0; start = 1'b0; stop = 1'b0; rdy16 = 1'b1; rdy32 = 1'b1;
      fixed_byte = 8'h3C; packet_head = 32'h5716EB90; flag_set = 16'hA5C3;
      set_cfg(2'b00, 24'd16, 16'd1, 8'd0);
      #12;
      chk_outputs_zero("reset");
      @(posedge clk); #1 nRST = 1'b1;

      // 1: L=16 incrementing, single packet, latency and done timing
      set_cfg(2'b00, 24'd16, 16'd1, 8'd0);
      push_packet(24'd0, 1'b1, 1'b1);
      do_start();
      @(negedge clk);
      chk("t1_busy_after_start", {busy16, busy32, if16.out_valid, if32.out_valid}, 4'b1100);
      @(negedge clk);
      chk("t1_first_valid", {if16.out_valid, if32.out_valid}, 2'b11);
      n = 1;
      while (!(if16.out_valid && if16.out_last) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t1_words16", n, 8);
      @(negedge clk);
      chk("t1_done_pulse", {done16, busy16, if16.out_valid}, 3'b110);
      @(negedge clk);
      chk("t1_done_fall", {done16, busy16}, 2'b00);
      run_until_idle(100, 1'b0);
      chk("t1_done_cnt", {16'(done16_cnt), 16'(done32_cnt)}, {16'd1, 16'd1});
      chk("t1_queues_empty", exp16_q.size() + exp32_q.size(), 0);

      // 2: L=20 incrementing, CRC sharing a 32-bit word with payload
      set_cfg(2'b00, 24'd20, 16'd1, 8'd0);
      push_packet(24'd0, 1'b1, 1'b1);
      do_start();
      run_until_idle(100, 1'b0);
      chk("t2_done_cnt", {16'(done16_cnt), 16'(done32_cnt)}, {16'd1, 16'd1});
      chk("t2_queues_empty", exp16_q.size() + exp32_q.size(), 0);

      // 3: PRBS payload, two packets, gap 1, random ready stalls
      set_cfg(2'b01, 24'd28, 16'd2, 8'd1);
      push_packet(24'd0, 1'b1, 1'b1);
      push_packet(24'd1, 1'b1, 1'b1);
      do_start();
      run_until_idle(2000, 1'b1);
      chk("t3_done_cnt", {16'(done16_cnt), 16'(done32_cnt)}, {16'd1, 16'd1});
      chk("t3_queues_empty", exp16_q.size() + exp32_q.size(), 0);

      // 4: fixed byte, three packets, gap 2, sequence numbers in header
      set_cfg(2'b10, 24'd16, 16'd3, 8'd2);
      for (int s = 0; s < 3; s++) push_packet(24'(s), 1'b1, 1'b1);
      do_start();
      run_until_idle(300, 1'b0);
      chk("t4_done_cnt", {16'(done16_cnt), 16'(done32_cnt)}, {16'd1, 16'd1});
      chk("t4_queues_empty", exp16_q.size() + exp32_q.size(), 0);

      // 5a: L=15 rejected by both widths
      set_cfg(2'b00, 24'd15, 16'd1, 8'd0);
      do_start();
      @(negedge clk);
      chk("t5a_no_err_yet", {cfg_err16, cfg_err32, busy16, busy32}, 4'b0000);
      @(negedge clk);
      chk("t5a_cfg_err", {cfg_err16, cfg_err32, busy16, busy32, if16.out_valid, if32.out_valid}, 6'b110000);
      @(negedge clk);
      chk("t5a_cfg_err_fall", {cfg_err16, cfg_err32, busy16, busy32}, 4'b0000);
      repeat (3) @(negedge clk);
      chk("t5a_stay_idle", {busy16, busy32, if16.out_valid, if32.out_valid}, 4'b0000);

      // 5b: L=18 rejected by the 32-bit instance only
      set_cfg(2'b00, 24'd18, 16'd1, 8'd0);
      push_packet(24'd0, 1'b1, 1'b0);
      do_start();
      @(negedge clk);
      @(negedge clk);
      chk("t5b_cfg_err", {cfg_err16, cfg_err32, busy32, if32.out_valid}, 4'b0100);
      run_until_idle(100, 1'b0);
      chk("t5b_done_cnt", {16'(done16_cnt), 16'(done32_cnt)}, {16'd1, 16'd0});
      chk("t5b_queues_empty", exp16_q.size() + exp32_q.size(), 0);

      // 6: stop mid-packet in continuous mode, back-to-back gap setting
      set_cfg(2'b00, 24'd32, 16'd0, 8'd0);
      push_packet(24'd0, 1'b1, 1'b1);
      do_start();
      repeat (3) @(negedge clk);
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      run_until_idle(300, 1'b0);
      chk("t6_no_done", {16'(done16_cnt), 16'(done32_cnt)}, {16'd0, 16'd0});
      chk("t6_queues_empty", exp16_q.size() + exp32_q.size(), 0);

      // 7: reset in the middle of a packet
      set_cfg(2'b01, 24'd64, 16'd0, 8'd0);
      push_packet(24'd0, 1'b1, 1'b1);
      do_start();
      repeat (5) @(negedge clk);
      chk("t7_running", {busy16, busy32, if16.out_valid, if32.out_valid}, 4'b1111);
      @(posedge clk); #1 nRST = 1'b0;
      #1 chk_outputs_zero("t7_async_reset");
      exp16_q.delete();
      exp32_q.delete();
      @(posedge clk); #1 nRST = 1'b1;
      repeat (4) @(negedge clk);
      chk("t7_no_resume", {busy16, busy32, if16.out_valid, if32.out_valid}, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
